bp_update_ctrl: RTL and testbench

//  Sequencer for the local branch predictor (BHT/PHT). Holds in-flight prediction metadata from

---
 rtl/bp_update_ctrl.sv | 142 ++++++++++++++
 tb/tb_bp_update_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: in-order sequencer for local branch predictor training.
// Ports: clk/rst_n; reinit; push_* (decode metadata in), push_ready;
//   resolve_valid/taken (M-stage outcome); upd_* predictor training port;
//   mispredict redirect pulse; init_valid/init_idx PHT init sweep; busy;
//   occupancy; sticky err_overflow/err_underflow.
module bp_update_ctrl #(
    parameter int PHT_INDEX_BITS = 7,
    parameter int BHT_INDEX_BITS = 3,
    parameter int QDEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reinit,
    input  logic                      push_valid,
    input  logic [PHT_INDEX_BITS-1:0] push_pht_idx,
    input  logic [BHT_INDEX_BITS-1:0] push_bht_idx,
    input  logic                      push_pred_taken,
    output logic                      push_ready,
    input  logic                      resolve_valid,
    input  logic                      resolve_taken,
    output logic                      upd_valid,
    output logic [PHT_INDEX_BITS-1:0] upd_pht_idx,
    output logic [BHT_INDEX_BITS-1:0] upd_bht_idx,
    output logic                      upd_taken,
    output logic                      mispredict,
    output logic                      init_valid,
    output logic [PHT_INDEX_BITS-1:0] init_idx,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   occupancy,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    localparam int PW = $clog2(QDEPTH);
    localparam int OW = PW + 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                    state;
    logic [PHT_INDEX_BITS-1:0] q_pht [QDEPTH];
    logic [BHT_INDEX_BITS-1:0] q_bht [QDEPTH];
    logic [QDEPTH-1:0]         q_pred;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;

    logic run;
    logic not_empty;
    logic do_pop;
    logic mis_now;
    logic do_push;
    logic full;

    assign run       = (state == S_RUN);
    assign not_empty = (occupancy != '0);
    assign full      = (occupancy == OW'(QDEPTH));
    assign do_pop    = run & resolve_valid & not_empty;
    assign mis_now   = do_pop & (q_pred[rd_ptr] != resolve_taken);
    // A correct resolve frees the head slot this edge, so a full FIFO
    // can still take a push in the same cycle.
    assign push_ready = run & ~mispredict & ~mis_now & (~full | do_pop);
    assign do_push    = push_valid & push_ready;

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pht[wr_ptr]  <= push_pht_idx;
            q_bht[wr_ptr]  <= push_bht_idx;
            q_pred[wr_ptr] <= push_pred_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            init_idx      <= '0;
            init_valid    <= 1'b0;
            busy          <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            upd_valid     <= 1'b0;
            upd_pht_idx   <= '0;
            upd_bht_idx   <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (!run) begin
            upd_valid  <= 1'b0;
            mispredict <= 1'b0;
            // First cycle out of reset only raises the strobe; the
            // sweep then covers every index once.
            if (!init_valid) begin
                init_valid <= 1'b1;
                busy       <= 1'b1;
            end else if (init_idx == '1) begin
                state      <= S_RUN;
                init_idx   <= '0;
                init_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                init_idx <= init_idx + PHT_INDEX_BITS'(1);
            end
        end else if (reinit) begin
            state      <= S_INIT;
            init_idx   <= '0;
            init_valid <= 1'b1;
            busy       <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            upd_valid  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= do_pop;
            mispredict <= mis_now;
            if (do_pop) begin
                upd_pht_idx <= q_pht[rd_ptr];
                upd_bht_idx <= q_bht[rd_ptr];
                upd_taken   <= resolve_taken;
            end
            // Everything still queued is younger than the
            // mispredicted branch, so it is all flushed.
            if (mis_now) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (do_pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (do_push)
                    wr_ptr <= wr_ptr + PW'(1);
                occupancy <= occupancy + OW'(do_push) - OW'(do_pop);
            end
            if (resolve_valid & ~not_empty)
                err_underflow <= 1'b1;
            if (push_valid & ~push_ready & ~mispredict & ~mis_now)
                err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed scenarios plus random traffic against a
// queue-based reference model of the predictor update sequencer.
module tb_bp_update_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reinit = 1'b0;
    logic       push_valid = 1'b0;
    logic [6:0] push_pht_idx = '0;
    logic [2:0] push_bht_idx = '0;
    logic       push_pred_taken = 1'b0;
    logic       push_ready;
    logic       resolve_valid = 1'b0;
    logic       resolve_taken = 1'b0;
    logic       upd_valid;
    logic [6:0] upd_pht_idx;
    logic [2:0] upd_bht_idx;
    logic       upd_taken;
    logic       mispredict;
    logic       init_valid;
    logic [6:0] init_idx;
    logic       busy;
    logic [2:0] occupancy;
    logic       err_overflow;
    logic       err_underflow;

    int checks = 0;
    int failures = 0;

    bp_update_ctrl #(
        .PHT_INDEX_BITS(7),
        .BHT_INDEX_BITS(3),
        .QDEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit),
        .push_valid(push_valid), .push_pht_idx(push_pht_idx),
        .push_bht_idx(push_bht_idx), .push_pred_taken(push_pred_taken),
        .push_ready(push_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .upd_valid(upd_valid), .upd_pht_idx(upd_pht_idx),
        .upd_bht_idx(upd_bht_idx), .upd_taken(upd_taken),
        .mispredict(mispredict), .init_valid(init_valid),
        .init_idx(init_idx), .busy(busy), .occupancy(occupancy),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int bh;
        bit pt;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    bit   m_init;
    int   m_sweep;   // -1: waiting for first clock, else index being written
    bit   m_uv, m_mis, m_ut, m_eo, m_eu;
    int   m_uph, m_ubh;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_init = 1; m_sweep = -1;
        m_uv = 0; m_mis = 0; m_ut = 0; m_eo = 0; m_eu = 0;
        m_uph = 0; m_ubh = 0;
    endtask

    task automatic check_outputs();
        bit iv;
        iv = m_init && (m_sweep >= 0);
        chk("init_valid", int'(init_valid), int'(iv));
        chk("busy", int'(busy), int'(iv));
        chk("init_idx", int'(init_idx), iv ? m_sweep : 0);
        chk("occupancy", int'(occupancy), mq.size());
        chk("upd_valid", int'(upd_valid), int'(m_uv));
        chk("upd_pht_idx", int'(upd_pht_idx), m_uph);
        chk("upd_bht_idx", int'(upd_bht_idx), m_ubh);
        chk("upd_taken", int'(upd_taken), int'(m_ut));
        chk("mispredict", int'(mispredict), int'(m_mis));
        chk("err_overflow", int'(err_overflow), int'(m_eo));
        chk("err_underflow", int'(err_underflow), int'(m_eu));
    endtask

    // One clock cycle: check state, apply inputs, check push_ready,
    // advance the model, then step to the next falling edge.
    task automatic cyc(input bit pv, input int ph, input int bh, input bit pt,
                       input bit rv, input bit rt, input bit ri);
        bit   run, head, mis_now, rdy, n_uv, n_mis;
        ent_t e;
        check_outputs();
        push_valid = pv; push_pht_idx = 7'(ph); push_bht_idx = 3'(bh);
        push_pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
        reinit = ri;
        #1;
        run = !m_init;
        head = mq.size() > 0;
        mis_now = run && rv && head && (mq[0].pt != rt);
        rdy = run && !m_mis && !mis_now && (mq.size() < 4 || (rv && head));
        chk("push_ready", int'(push_ready), int'(rdy));
        n_uv = 0; n_mis = 0;
        if (m_init) begin
            m_sweep++;
            if (m_sweep == 128) begin
                m_init = 0; m_sweep = -1;
            end
        end else if (ri) begin
            mq.delete();
            m_init = 1; m_sweep = 0;
        end else begin
            if (rv && head) begin
                e = mq.pop_front();
                n_uv = 1; n_mis = (e.pt != rt);
                m_uph = e.ph; m_ubh = e.bh; m_ut = rt;
            end else if (rv) begin
                m_eu = 1;
            end
            if (pv && rdy) begin
                e.ph = ph; e.bh = bh; e.pt = pt;
                mq.push_back(e);
            end else if (pv && !m_mis && !mis_now) begin
                m_eo = 1;
            end
            if (mis_now) mq.delete();
        end
        m_uv = n_uv; m_mis = n_mis;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input bit pt);
        cyc(1, $urandom_range(127), $urandom_range(7), pt, 0, 0, 0);
    endtask

    task automatic resolve(input bit rt);
        cyc(0, 0, 0, 0, 1, rt, 0);
    endtask

    // Called on a falling edge: reset is asserted and released before
    // the next rising edge.
    task automatic do_reset();
        push_valid = 0; resolve_valid = 0; reinit = 0;
        rst_n = 0;
        model_reset();
        #2;
        check_outputs();
        rst_n = 1;
    endtask

    task automatic wait_sweep();
        int n = 0;
        for (int i = 0; i < 300 && m_init; i++) begin
            if (busy && init_valid) n++;
            idle();
        end
        chk("sweep_len", n, 128);
    endtask

    initial begin
        @(negedge clk);
        // T1: reset and full init sweep
        do_reset();
        wait_sweep();
        idle();

        // T2: four correct predictions
        push(1); push(1); push(0); push(1);
        resolve(1); resolve(1); resolve(0); resolve(1);
        idle(); idle();

        // T3: mispredict flushes, pushes in the two cycles dropped
        push(1); push(1); push(1);
        cyc(1, 5, 2, 1, 1, 0, 0);
        cyc(1, 6, 3, 1, 0, 0, 0);
        idle(); idle();

        // T4: full FIFO, push + correct resolve, then overflow
        push(0); push(1); push(0); push(1);
        cyc(1, 9, 4, 0, 1, 0, 0);
        push(1);
        idle();
        for (int i = 0; i < 4; i++) resolve(mq.size() > 0 ? mq[0].pt : 1'b0);
        idle();

        // T5: resolve on empty FIFO, sticky underflow
        resolve(1);
        idle(); idle();
        push(1); resolve(1); idle();

        // T6: reinit with entries queued, reset mid-sweep
        push(1); push(0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) idle();
        do_reset();
        wait_sweep();
        idle();

        // Random traffic, occasional reinit
        for (int i = 0; i < 1500; i++) begin
            if (!m_init && $urandom_range(199) == 0)
                cyc(0, 0, 0, 0, 0, 0, 1);
            else
                cyc($urandom_range(2) != 0, $urandom_range(127),
                    $urandom_range(7), $urandom_range(1) == 1,
                    $urandom_range(2) == 0, $urandom_range(3) != 0, 0);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
